debug_cmd_unit: RTL and testbench
=================================

DEBUG_CMD_UNIT -- requirements
Module: debug_cmd_unit

Interface
REQ-001 Parameter WORD_LENGTH, default 8: width of received UART byte.
REQ-002 Parameter SYNC_LEN, default 2: number of consecutive SYNC_BYTE values required to leave IDLE.
REQ-003 Parameter SYNC_BYTE, default 8'hFF: sync pattern value.
REQ-004 Parameter CC_LENGTH, default 11: width of enabled-cycle counter.
REQ-005 Parameters CMD_RUN/CMD_STEP/CMD_STOP/CMD_RESET, defaults 8'h01/8'h02/8'h03/8'h04: command byte codes.
REQ-006 i_clock  input  1  single clock; all state updates on rising edge.
REQ-007 i_reset  input  1  asynchronous, active-low reset.
REQ-008 i_rx_done  input  1  UART receiver done flag; a byte is valid on its high-to-low transition.
REQ-009 i_data_rx  input  WORD_LENGTH  received byte, valid on the byte-event cycle.
REQ-010 i_halt  input  1  pipeline halt indication (HALT instruction retired).
REQ-011 o_soft_reset  output  1  release for processor modules; 0 holds them in reset.
REQ-012 o_enable  output  1  processor clock-enable.
REQ-013 o_cycle_count  output  CC_LENGTH  number of cycles with o_enable=1 since leaving IDLE.
REQ-014 o_state  output  3  current state encoding: IDLE=0, READY=1, RUN=2, STEP=3, HALTED=4.
REQ-015 o_cmd_error  output  1  one-cycle pulse on an illegal command byte.

Function
REQ-016 Byte event SHALL be (registered i_rx_done)=1 and i_rx_done=0; exactly one event per falling edge; i_data_rx sampled in that cycle.
REQ-017 All outputs SHALL be registered, updated on the same edge as state.
REQ-018 IDLE: event with byte==SYNC_BYTE increments sync counter; any other byte clears it to 0.
REQ-019 IDLE: on the event that makes sync count equal SYNC_LEN, next state READY and sync counter cleared.
REQ-020 o_soft_reset SHALL be 1 in every state except IDLE; 0 in IDLE.
REQ-021 READY: CMD_RUN -> RUN; CMD_STEP -> STEP; CMD_RESET -> IDLE; CMD_STOP -> stay, no error; other byte -> stay, o_cmd_error pulse.
REQ-022 RUN: o_enable=1 every cycle in RUN; CMD_STOP -> READY; CMD_RESET -> IDLE; i_halt=1 -> HALTED; CMD_RUN/CMD_STEP ignored; other byte -> o_cmd_error pulse, stay.
REQ-023 STEP: o_enable=1 for exactly one cycle, then READY, or HALTED if i_halt=1 in that cycle; byte events in STEP other than CMD_RESET are ignored.
REQ-024 HALTED: o_enable=0; only CMD_RESET accepted (-> IDLE); any other byte -> o_cmd_error pulse, stay.
REQ-025 Priority in one cycle: CMD_RESET > i_halt > other commands.
REQ-026 i_halt SHALL be ignored in IDLE and READY.
REQ-027 o_cycle_count increments by 1 on each cycle o_enable=1; saturates at 2^CC_LENGTH-1 (no wrap).
REQ-028 o_cycle_count cleared to 0 on entry to IDLE; held in READY and HALTED.
REQ-029 o_cmd_error SHALL never be high for more than one consecutive cycle per byte event; never asserted in IDLE.
REQ-030 Entering IDLE via CMD_RESET clears sync counter; o_soft_reset and o_enable drop to 0 on that same edge.

Reset
REQ-031 i_reset=0 SHALL immediately, without clock, force: state IDLE, sync counter 0, registered rx_done 0, o_soft_reset 0, o_enable 0, o_cycle_count 0, o_state 0, o_cmd_error 0.
REQ-032 Reset asserted mid-RUN SHALL abort execution identically; after release, SYNC_LEN sync bytes are required again.
REQ-033 A falling edge of i_rx_done coincident with reset release SHALL NOT produce a byte event.

Verification
REQ-034 Bytes FF, FF (defaults) -> o_state 0->1 after second event, o_soft_reset=1, o_enable=0.
REQ-035 Bytes FF, 12, FF -> remains IDLE (counter cleared by 12); one more FF -> READY.
REQ-036 READY, byte 02 -> o_enable=1 for exactly one cycle, o_cycle_count=1, state back to READY; byte 07 -> o_cmd_error one-cycle pulse.
REQ-037 READY, byte 01, i_halt=1 after 5 cycles -> o_enable high 5 cycles, HALTED, o_cycle_count=5; byte 01 -> o_cmd_error; byte 04 -> IDLE, count 0, o_soft_reset 0.
REQ-038 CC_LENGTH=3, RUN 20 cycles -> o_cycle_count saturates at 7.
REQ-039 RUN, i_reset pulsed low between clock edges -> outputs 0 asynchronously; FF, FF required to re-enter READY.

Source files
------------

// File: rtl/debug_cmd_unit.sv
// Debug command sequencer: waits for a UART sync preamble, then runs, single-steps,
// stops or resets the processor on command bytes, counting enabled cycles.
module debug_cmd_unit #(
  parameter int                     WORD_LENGTH = 8,
  parameter int                     SYNC_LEN    = 2,
  parameter logic [WORD_LENGTH-1:0] SYNC_BYTE   = 8'hFF,
  parameter int                     CC_LENGTH   = 11,
  parameter logic [WORD_LENGTH-1:0] CMD_RUN     = 8'h01,
  parameter logic [WORD_LENGTH-1:0] CMD_STEP    = 8'h02,
  parameter logic [WORD_LENGTH-1:0] CMD_STOP    = 8'h03,
  parameter logic [WORD_LENGTH-1:0] CMD_RESET   = 8'h04
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_rx_done,
  input  logic [WORD_LENGTH-1:0] i_data_rx,
  input  logic                   i_halt,
  output logic                   o_soft_reset,
  output logic                   o_enable,
  output logic [CC_LENGTH-1:0]   o_cycle_count,
  output logic [2:0]             o_state,
  output logic                   o_cmd_error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam int                  SYNC_W    = $clog2(SYNC_LEN + 1);
  localparam logic [SYNC_W-1:0]   SYNC_LAST = SYNC_W'(SYNC_LEN - 1);
  localparam logic [CC_LENGTH-1:0] CC_MAX   = '1;

  state_t            state;
  state_t            state_nxt;
  logic              rx_q;
  logic              byte_evt;
  logic              is_reset_cmd;
  logic              err_nxt;
  logic              enable_nxt;
  logic [SYNC_W-1:0] sync_cnt;
  logic [SYNC_W-1:0] sync_nxt;

  // A byte is delivered on the falling edge of rx_done; rx_q is cleared by reset,
  // so a falling edge coincident with reset release cannot register as an event.
  assign byte_evt     = rx_q & ~i_rx_done;
  assign is_reset_cmd = byte_evt && (i_data_rx == CMD_RESET);

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    sync_nxt  = '0;
    case (state)
      IDLE: begin
        sync_nxt = sync_cnt;
        if (byte_evt) begin
          if (i_data_rx != SYNC_BYTE) begin
            sync_nxt = '0;
          end else if (sync_cnt == SYNC_LAST) begin
            state_nxt = READY;
            sync_nxt  = '0;
          end else begin
            sync_nxt = sync_cnt + 1'b1;
          end
        end
      end
      READY: begin
        if (byte_evt) begin
          if (i_data_rx == CMD_RUN)         state_nxt = RUN;
          else if (i_data_rx == CMD_STEP)   state_nxt = STEP;
          else if (i_data_rx == CMD_RESET)  state_nxt = IDLE;
          else if (i_data_rx != CMD_STOP)   err_nxt   = 1'b1;
        end
      end
      RUN: begin
        // Reset command outranks halt, which outranks every other command.
        if (is_reset_cmd) begin
          state_nxt = IDLE;
        end else if (i_halt) begin
          state_nxt = HALTED;
        end else if (byte_evt) begin
          if (i_data_rx == CMD_STOP) state_nxt = READY;
          else if (i_data_rx != CMD_RUN && i_data_rx != CMD_STEP) err_nxt = 1'b1;
        end
      end
      STEP: begin
        if (is_reset_cmd)  state_nxt = IDLE;
        else if (i_halt)   state_nxt = HALTED;
        else               state_nxt = READY;
      end
      HALTED: begin
        if (is_reset_cmd)  state_nxt = IDLE;
        else if (byte_evt) err_nxt   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enable_nxt = (state_nxt == RUN) || (state_nxt == STEP);
  assign o_state    = state;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      rx_q          <= 1'b0;
      sync_cnt      <= '0;
      o_soft_reset  <= 1'b0;
      o_enable      <= 1'b0;
      o_cycle_count <= '0;
      o_cmd_error   <= 1'b0;
    end else begin
      state        <= state_nxt;
      rx_q         <= i_rx_done;
      sync_cnt     <= sync_nxt;
      o_soft_reset <= (state_nxt != IDLE);
      o_enable     <= enable_nxt;
      o_cmd_error  <= err_nxt;
      // Count tracks the enable being registered on this edge, so it already
      // includes the current enabled cycle; saturate rather than wrap.
      if (state_nxt == IDLE)
        o_cycle_count <= '0;
      else if (enable_nxt && o_cycle_count != CC_MAX)
        o_cycle_count <= o_cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_cmd_unit.sv
// Randomized bench for debug_cmd_unit with an in-bench behavioural model and
// directed scenarios pinning sync, step, run/halt, saturation and async reset.
module tb_debug_cmd_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] data = 8'h00;
  logic       halt = 1'b0;

  logic        soft_reset, enable, cmd_error;
  logic [10:0] cycle_count;
  logic [2:0]  state;
  logic        soft_reset3, enable3, cmd_error3;
  logic [2:0]  cycle_count3;
  logic [2:0]  state3;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rnd_mode = 1'b0;

  always #5 clk = ~clk;

  debug_cmd_unit dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_done(rx_done), .i_data_rx(data), .i_halt(halt),
    .o_soft_reset(soft_reset), .o_enable(enable), .o_cycle_count(cycle_count),
    .o_state(state), .o_cmd_error(cmd_error)
  );

  debug_cmd_unit #(.CC_LENGTH(3)) dut3 (
    .i_clock(clk), .i_reset(rst_n), .i_rx_done(rx_done), .i_data_rx(data), .i_halt(halt),
    .o_soft_reset(soft_reset3), .o_enable(enable3), .o_cycle_count(cycle_count3),
    .o_state(state3), .o_cmd_error(cmd_error3)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 ready, 2 run, 3 step, 4 halted.
  int m_mode = 0, m_sync = 0, m_cnt = 0, m_cnt3 = 0;
  bit m_prev = 1'b0, m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_sync <= 0; m_cnt <= 0; m_cnt3 <= 0; m_prev <= 1'b0; m_err <= 1'b0;
    end else begin : model
      int mode, sync, cnt, cnt3;
      bit ev, err;
      ev = m_prev && !rx_done;
      mode = m_mode; sync = m_sync; err = 1'b0;
      if (ev && mode != 0 && data == 8'h04) mode = 0;
      else if (mode == 0) begin
        if (ev) sync = (data == 8'hFF) ? sync + 1 : 0;
        if (sync == 2) begin mode = 1; sync = 0; end
      end
      else if (mode == 2 && halt) mode = 4;
      else if (mode == 3) mode = halt ? 4 : 1;
      else if (ev) begin
        if (mode == 1) begin
          if (data == 8'h01) mode = 2;
          else if (data == 8'h02) mode = 3;
          else if (data != 8'h03) err = 1'b1;
        end else if (mode == 2) begin
          if (data == 8'h03) mode = 1;
          else if (data != 8'h01 && data != 8'h02) err = 1'b1;
        end else begin
          err = 1'b1;
        end
      end
      cnt = m_cnt; cnt3 = m_cnt3;
      if (mode == 0) begin
        cnt = 0; cnt3 = 0;
      end else if (mode == 2 || mode == 3) begin
        if (cnt < 2047) cnt = cnt + 1;
        if (cnt3 < 7) cnt3 = cnt3 + 1;
      end
      m_mode <= mode; m_sync <= sync; m_cnt <= cnt; m_cnt3 <= cnt3;
      m_err <= err; m_prev <= rx_done;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(state), m_mode);
      chk("soft_reset", int'(soft_reset), int'(m_mode != 0));
      chk("enable", int'(enable), int'(m_mode == 2 || m_mode == 3));
      chk("cmd_error", int'(cmd_error), int'(m_err));
      chk("cycle_count", int'(cycle_count), m_cnt);
      chk("cycle_count_cc3", int'(cycle_count3), m_cnt3);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_mode) begin
      halt = ($urandom_range(0, 11) == 0);
      if (!rx_done) data = 8'($urandom);
    end
  endtask

  // Returns on the negedge just after the byte-event edge.
  task automatic send_byte(input logic [7:0] b);
    tick();
    data = b; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic resync();
    send_byte(8'h04);
    send_byte(8'hFF);
    send_byte(8'hFF);
    chk("resync_ready", int'(state), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pick;
    logic [7:0] b;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_soft", int'(soft_reset), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_count", int'(cycle_count), 0);
    chk("rst_err", int'(cmd_error), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Two sync bytes reach READY.
    send_byte(8'hFF);
    chk("one_ff_idle", int'(state), 0);
    send_byte(8'hFF);
    chk("ff_ff_ready", int'(state), 1);
    chk("ff_ff_soft", int'(soft_reset), 1);
    chk("ff_ff_enable", int'(enable), 0);

    // A non-sync byte clears the sync count.
    send_byte(8'h04);
    send_byte(8'hFF);
    send_byte(8'h12);
    send_byte(8'hFF);
    chk("ff12ff_idle", int'(state), 0);
    send_byte(8'hFF);
    chk("ff12ffff_ready", int'(state), 1);

    // Single step.
    send_byte(8'h02);
    chk("step_enable", int'(enable), 1);
    chk("step_count", int'(cycle_count), 1);
    @(negedge clk);
    chk("step_enable_drop", int'(enable), 0);
    chk("step_back_ready", int'(state), 1);

    // Illegal command pulses error for one cycle.
    send_byte(8'h07);
    chk("bad_cmd_err", int'(cmd_error), 1);
    @(negedge clk);
    chk("bad_cmd_err_drop", int'(cmd_error), 0);

    // Run for five cycles then halt.
    resync();
    send_byte(8'h01);
    chk("run_state", int'(state), 2);
    repeat (4) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("halted_state", int'(state), 4);
    chk("halted_count", int'(cycle_count), 5);
    chk("halted_enable", int'(enable), 0);
    send_byte(8'h01);
    chk("halted_run_err", int'(cmd_error), 1);
    send_byte(8'h04);
    chk("reset_cmd_idle", int'(state), 0);
    chk("reset_cmd_count", int'(cycle_count), 0);
    chk("reset_cmd_soft", int'(soft_reset), 0);

    // Saturation of the narrow counter over twenty run cycles.
    resync();
    send_byte(8'h01);
    repeat (19) @(negedge clk);
    chk("run20_count", int'(cycle_count), 20);
    chk("run20_count_cc3", int'(cycle_count3), 7);
    send_byte(8'h03);
    chk("stop_ready", int'(state), 1);

    // Asynchronous reset mid-run, released with a coincident rx_done fall.
    send_byte(8'h01);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_enable", int'(enable), 0);
    chk("async_soft", int'(soft_reset), 0);
    chk("async_count", int'(cycle_count), 0);
    @(negedge clk);
    data = 8'hFF; rx_done = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; rx_done = 1'b0;
    @(negedge clk);
    send_byte(8'hFF);
    chk("release_no_event", int'(state), 0);
    send_byte(8'hFF);
    chk("post_reset_ready", int'(state), 1);

    // Randomized traffic.
    rnd_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1:    b = 8'hFF;
        2, 3:    b = 8'h01;
        4:       b = 8'h02;
        5:       b = 8'h03;
        6:       b = 8'h04;
        default: b = 8'($urandom);
      endcase
      send_byte(b);
      repeat ($urandom_range(0, 4)) tick();
    end
    rnd_mode = 1'b0;
    halt = 1'b0;
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
